rr_trace_buf_sched: RTL and testbench
=====================================

RR_TRACE_BUF_SCHED -- requirements
Module: rr_trace_buf_sched

Interface
REQ-001 SHALL have parameter DESC_DEPTH, default 4, meaning descriptor FIFO entries (power of 2, ≥2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, meaning host buffer address width.
REQ-003 SHALL have parameter SIZE_WIDTH, default 64, meaning host buffer size width (bytes).
REQ-004 SHALL have ports as follows (one clock; reset is asynchronous and active-high):
  clk  in  1  sole clock, all logic on posedge
  rst  in  1  asynchronous active-high reset
  desc_push  in  1  enqueue {desc_addr, desc_size} this cycle
  desc_addr  in  ADDR_WIDTH  host buffer base address
  desc_size  in  SIZE_WIDTH  host buffer size
  desc_full  out  1  FIFO holds DESC_DEPTH entries
  desc_count  out  $clog2(DESC_DEPTH+1)  queued descriptors
  mode  in  1  0 = record, 1 = replay; sampled on accepted start
  start  in  1  single-cycle pulse, begin session
  stop  in  1  single-cycle pulse, end session
  buf_done  in  1  single-cycle pulse, current buffer consumed (trace_rw interrupt)
  buf_addr  out  ADDR_WIDTH  active buffer address to trace_rw
  buf_size  out  SIZE_WIDTH  active buffer size to trace_rw
  write_buf_update  out  1  pulse, load buffer for record
  read_buf_update  out  1  pulse, load buffer for replay
  record_finish  out  1  pulse, force trace_rw record flush
  busy  out  1  state != IDLE
  starved  out  1  state == WAIT_DESC
  done_cnt  out  32  buffers completed since last accepted start
  err_overflow  out  1  sticky, push dropped while full

Function
REQ-005 FSM states SHALL be IDLE, WAIT_DESC, ISSUE, RUN, DRAIN; all outputs registered.
REQ-006 IDLE: start -> ISSUE if FIFO non-empty else WAIT_DESC; accepted start latches mode, clears done_cnt and err_overflow; stop ignored.
REQ-007 WAIT_DESC: stop -> IDLE with record_finish pulse if record mode; else push -> ISSUE next cycle.
REQ-008 ISSUE: lasts exactly one cycle; pops head, registers buf_addr/buf_size, pulses write_buf_update (record) or read_buf_update (replay) for one cycle coincident with entry to RUN.
REQ-009 Latency: start at cycle T with non-empty FIFO -> update pulse and new buf_addr/buf_size visible at T+2.
REQ-010 buf_addr/buf_size SHALL hold until next ISSUE; never change outside ISSUE.
REQ-011 RUN: buf_done -> done_cnt+1, then ISSUE if FIFO non-empty else WAIT_DESC.
REQ-012 RUN: stop (or stop latched during ISSUE) -> DRAIN; record mode pulses record_finish next cycle; replay no pulse.
REQ-013 RUN: simultaneous buf_done and stop -> done_cnt+1, IDLE, record_finish pulse in record mode.
REQ-014 DRAIN: buf_done -> done_cnt+1, IDLE; further stop ignored.
REQ-015 buf_done in IDLE, WAIT_DESC, ISSUE SHALL be ignored.
REQ-016 Push when full SHALL be dropped and set err_overflow, except push coincident with ISSUE pop, which is accepted.
REQ-017 FIFO SHALL wrap pointers modulo DESC_DEPTH; desc_count exact at every cycle; push accepted in any state.
REQ-018 done_cnt SHALL wrap 2^32-1 -> 0; mode changes while busy SHALL be ignored.

Reset
REQ-019 rst SHALL asynchronously force IDLE, empty FIFO, all outputs 0, stop_pending/mode cleared, including mid-RUN; no record_finish on reset.

Structure
REQ-020 State enum and descriptor struct {addr, size} SHALL live in shared package rr_trace_sched_pkg.
REQ-021 Descriptor queue SHALL be sub-module rr_trace_desc_fifo (push/pop/full/empty/count); FSM in top.

Verification
REQ-022 Push A=0x1000/0x4000, B=0x9000/0x4000, start record -> write_buf_update at T+2 with 0x1000; buf_done -> update with 0x9000; done_cnt=1.
REQ-023 Start with empty FIFO -> starved=1, no update; push 0x2000/0x100 -> read_buf_update (replay) two cycles later, starved=0.
REQ-024 Record RUN, stop -> record_finish one pulse, DRAIN; buf_done -> IDLE, busy=0, done_cnt incremented.
REQ-025 Push 5 with DESC_DEPTH=4 -> desc_full=1, 5th dropped, err_overflow=1; push during ISSUE pop while full accepted, count stays 4.
REQ-026 buf_done and stop same cycle in RUN -> IDLE directly, done_cnt+1, one record_finish.
REQ-027 rst asserted mid-RUN with 3 queued -> immediate IDLE, desc_count=0, all outputs 0.

Source files
------------

// File: rtl/rr_trace_sched_pkg.sv
// Shared types for the trace buffer scheduler.
//   sched_state_t : scheduler FSM states
//   mode_t        : session direction (record / replay)
//   desc_t        : queued host buffer descriptor {addr, size}
// Descriptor fields are carried at DESC_FIELD_W bits. Wrappers with narrower
// address/size ports zero-extend on the way in and truncate on the way out,
// so ADDR_WIDTH and SIZE_WIDTH must not exceed DESC_FIELD_W.
package rr_trace_sched_pkg;

  localparam int DESC_FIELD_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DESC = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4
  } sched_state_t;

  typedef enum logic {
    MODE_RECORD = 1'b0,
    MODE_REPLAY = 1'b1
  } mode_t;

  typedef struct packed {
    logic [DESC_FIELD_W-1:0] addr;
    logic [DESC_FIELD_W-1:0] size;
  } desc_t;

endpackage

// File: rtl/rr_trace_desc_fifo.sv
// Descriptor FIFO for the trace buffer scheduler.
//   clk, rst : clock, asynchronous active-high reset (empties the queue)
//   push     : enqueue wdata; dropped when full unless pop is also asserted
//   pop      : dequeue head (rdata is the head, valid while !empty)
//   wdata    : descriptor to enqueue
//   rdata    : head descriptor
//   full     : registered, count == DEPTH
//   empty    : count == 0
//   count    : number of queued descriptors
//   drop     : combinational, push rejected this cycle
// DEPTH must be a power of two so the pointers wrap naturally.
module rr_trace_desc_fifo
  import rr_trace_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  desc_t                          wdata,
  output desc_t                          rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  desc_t             mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_ok;
  logic              push_ok;
  logic [CNT_W-1:0]  count_next;

  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop frees the slot in the same cycle, so a push against a full queue
  // is still accepted when it coincides with a pop.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers and count, so clearing the payload would only cost flops.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/rr_trace_buf_sched.sv
// Round-robin trace buffer scheduler: queues host buffer descriptors and
// hands them one at a time to trace_rw for a record or replay session.
//   clk, rst          : clock, asynchronous active-high reset
//   desc_push/addr/size : enqueue a host buffer descriptor (any state)
//   desc_full, desc_count : queue status
//   mode              : 0 record / 1 replay, latched on an accepted start
//   start, stop       : session control pulses
//   buf_done          : trace_rw finished the active buffer
//   buf_addr/buf_size : active buffer, changes only when leaving ISSUE
//   write_buf_update / read_buf_update : load pulse for record / replay
//   record_finish     : flush pulse on record-session stop
//   busy, starved     : state != IDLE, state == WAIT_DESC
//   done_cnt          : buffers completed since the last accepted start
//   err_overflow      : sticky, a push was dropped while full
module rr_trace_buf_sched
  import rr_trace_sched_pkg::*;
#(
  parameter int DESC_DEPTH = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              desc_push,
  input  logic [ADDR_WIDTH-1:0]             desc_addr,
  input  logic [SIZE_WIDTH-1:0]             desc_size,
  output logic                              desc_full,
  output logic [$clog2(DESC_DEPTH+1)-1:0]   desc_count,
  input  logic                              mode,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              buf_done,
  output logic [ADDR_WIDTH-1:0]             buf_addr,
  output logic [SIZE_WIDTH-1:0]             buf_size,
  output logic                              write_buf_update,
  output logic                              read_buf_update,
  output logic                              record_finish,
  output logic                              busy,
  output logic                              starved,
  output logic [31:0]                       done_cnt,
  output logic                              err_overflow
);

  sched_state_t state;
  sched_state_t state_next;
  mode_t        mode_q;
  logic         stop_pending;
  logic         stop_now;
  logic         start_ok;
  logic         finish;
  logic         count_done;

  desc_t        fifo_wdata;
  desc_t        fifo_head;
  logic         fifo_pop;
  logic         fifo_empty;
  logic         fifo_drop;

  assign fifo_wdata = '{addr: DESC_FIELD_W'(desc_addr), size: DESC_FIELD_W'(desc_size)};
  assign fifo_pop   = (state == ST_ISSUE);

  rr_trace_desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (desc_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (desc_full),
    .empty (fifo_empty),
    .count (desc_count),
    .drop  (fifo_drop)
  );

  // A stop seen during the one-cycle ISSUE is honoured on the first RUN cycle.
  assign stop_now = stop || stop_pending;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    finish     = 1'b0;
    count_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = fifo_empty ? ST_WAIT_DESC : ST_ISSUE;
        end
      end
      ST_WAIT_DESC: begin
        if (stop) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end else if (desc_push || !fifo_empty) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_RUN;
      ST_RUN: begin
        if (buf_done) begin
          count_done = 1'b1;
          if (stop_now) begin
            state_next = ST_IDLE;
            finish     = 1'b1;
          end else begin
            state_next = fifo_empty ? ST_WAIT_DESC : ST_ISSUE;
          end
        end else if (stop_now) begin
          state_next = ST_DRAIN;
          finish     = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (buf_done) begin
          count_done = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      mode_q           <= MODE_RECORD;
      stop_pending     <= 1'b0;
      buf_addr         <= '0;
      buf_size         <= '0;
      write_buf_update <= 1'b0;
      read_buf_update  <= 1'b0;
      record_finish    <= 1'b0;
      busy             <= 1'b0;
      starved          <= 1'b0;
      done_cnt         <= '0;
      err_overflow     <= 1'b0;
    end else begin
      state   <= state_next;
      busy    <= (state_next != ST_IDLE);
      starved <= (state_next == ST_WAIT_DESC);

      if (start_ok) mode_q <= mode_t'(mode);

      if (state == ST_ISSUE)     stop_pending <= stop;
      else if (state == ST_RUN)  stop_pending <= 1'b0;

      if (state == ST_ISSUE) begin
        buf_addr <= fifo_head.addr[ADDR_WIDTH-1:0];
        buf_size <= fifo_head.size[SIZE_WIDTH-1:0];
      end
      write_buf_update <= (state == ST_ISSUE) && (mode_q == MODE_RECORD);
      read_buf_update  <= (state == ST_ISSUE) && (mode_q == MODE_REPLAY);
      record_finish    <= finish && (mode_q == MODE_RECORD);

      if (start_ok)        done_cnt <= '0;
      else if (count_done) done_cnt <= done_cnt + 32'd1;

      // A drop in the same cycle as start still counts for the new session.
      if (fifo_drop)      err_overflow <= 1'b1;
      else if (start_ok)  err_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_trace_buf_sched.sv
module tb_rr_trace_buf_sched;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          desc_push = 1'b0;
  logic [63:0]   desc_addr = '0;
  logic [63:0]   desc_size = '0;
  logic          desc_full;
  logic [CW-1:0] desc_count;
  logic          mode = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          buf_done = 1'b0;
  logic [63:0]   buf_addr;
  logic [63:0]   buf_size;
  logic          write_buf_update;
  logic          read_buf_update;
  logic          record_finish;
  logic          busy;
  logic          starved;
  logic [31:0]   done_cnt;
  logic          err_overflow;

  always #5 clk = ~clk;

  rr_trace_buf_sched #(
    .DESC_DEPTH (DEPTH),
    .ADDR_WIDTH (64),
    .SIZE_WIDTH (64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .desc_push        (desc_push),
    .desc_addr        (desc_addr),
    .desc_size        (desc_size),
    .desc_full        (desc_full),
    .desc_count       (desc_count),
    .mode             (mode),
    .start            (start),
    .stop             (stop),
    .buf_done         (buf_done),
    .buf_addr         (buf_addr),
    .buf_size         (buf_size),
    .write_buf_update (write_buf_update),
    .read_buf_update  (read_buf_update),
    .record_finish    (record_finish),
    .busy             (busy),
    .starved          (starved),
    .done_cnt         (done_cnt),
    .err_overflow     (err_overflow)
  );

  // ---------------- reference model ----------------
  typedef struct { logic [63:0] addr; logic [63:0] size; } mdesc_t;
  typedef struct { bit wr; logic [63:0] addr; logic [63:0] size; } upd_t;
  typedef struct {
    int          count;
    bit          full, bsy, stv, err;
    logic [31:0] done;
    logic [63:0] addr, size;
    logic [2:0]  pulses;
  } st_t;
  typedef enum { P_IDLE, P_WAIT, P_ISSUE, P_RUN, P_DRAIN } phase_e;

  mdesc_t      m_q[$];
  upd_t        exp_upd[$];
  st_t         exp_st[$];
  phase_e      m_phase = P_IDLE;
  bit          m_replay, m_latched, m_err;
  logic [31:0] m_done;
  logic [63:0] m_addr, m_size;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = P_IDLE; m_replay = 0; m_latched = 0; m_err = 0;
    m_done = '0; m_addr = '0; m_size = '0;
  endtask

  // Applies one clock edge worth of behaviour to the model, using the inputs
  // currently driven, and queues what the DUT must show after that edge.
  task automatic model_step();
    bit     was_empty, uw, ur, fin, halt;
    phase_e nxt;
    st_t    s;
    upd_t   u;
    was_empty = (m_q.size() == 0);
    uw = 0; ur = 0; fin = 0;
    nxt = m_phase;
    case (m_phase)
      P_IDLE: if (start) begin
        m_replay = mode; m_done = '0; m_err = 0; m_latched = 0;
        nxt = was_empty ? P_WAIT : P_ISSUE;
      end
      P_WAIT: begin
        if (stop) begin nxt = P_IDLE; fin = !m_replay; end
        else if (desc_push || !was_empty) nxt = P_ISSUE;
      end
      P_ISSUE: begin
        if (m_q.size() > 0) begin
          m_addr = m_q[0].addr; m_size = m_q[0].size;
          void'(m_q.pop_front());
        end
        uw = !m_replay; ur = m_replay;
        u.wr = !m_replay; u.addr = m_addr; u.size = m_size;
        exp_upd.push_back(u);
        m_latched = stop;
        nxt = P_RUN;
      end
      P_RUN: begin
        halt = stop || m_latched;
        m_latched = 0;
        if (buf_done) begin
          m_done = m_done + 1;
          if (halt) begin nxt = P_IDLE; fin = !m_replay; end
          else nxt = was_empty ? P_WAIT : P_ISSUE;
        end else if (halt) begin
          nxt = P_DRAIN; fin = !m_replay;
        end
      end
      P_DRAIN: if (buf_done) begin m_done = m_done + 1; nxt = P_IDLE; end
      default: nxt = P_IDLE;
    endcase
    if (desc_push) begin
      if (m_q.size() < DEPTH) m_q.push_back('{addr: desc_addr, size: desc_size});
      else m_err = 1;
    end
    m_phase = nxt;
    s.count = m_q.size(); s.full = (m_q.size() == DEPTH);
    s.bsy = (m_phase != P_IDLE); s.stv = (m_phase == P_WAIT);
    s.done = m_done; s.err = m_err; s.addr = m_addr; s.size = m_size;
    s.pulses = {uw, ur, fin};
    exp_st.push_back(s);
  endtask

  // ---------------- monitor ----------------
  initial begin
    st_t  e;
    upd_t u;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst) begin
        check("status_available", 64'(exp_st.size() > 0), 64'd1);
        if (exp_st.size() > 0) begin
          e = exp_st.pop_front();
          check("desc_count", 64'(desc_count), 64'(e.count));
          check("desc_full", 64'(desc_full), 64'(e.full));
          check("busy", 64'(busy), 64'(e.bsy));
          check("starved", 64'(starved), 64'(e.stv));
          check("done_cnt", 64'(done_cnt), 64'(e.done));
          check("err_overflow", 64'(err_overflow), 64'(e.err));
          check("buf_addr", buf_addr, e.addr);
          check("buf_size", buf_size, e.size);
          check("pulses{wr,rd,fin}", 64'({write_buf_update, read_buf_update, record_finish}),
                64'(e.pulses));
        end
        if (write_buf_update || read_buf_update) begin
          check("update_expected", 64'(exp_upd.size() > 0), 64'd1);
          if (exp_upd.size() > 0) begin
            u = exp_upd.pop_front();
            check("update_kind_write", 64'(write_buf_update), 64'(u.wr));
            check("update_addr", buf_addr, u.addr);
            check("update_size", buf_size, u.size);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit p, input logic [63:0] a, input logic [63:0] sz,
                       input bit md, input bit st, input bit sp, input bit dn);
    @(negedge clk);
    mon_en = 1'b1;
    desc_push = p; desc_addr = a; desc_size = sz;
    mode = md; start = st; stop = sp; buf_done = dn;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic push_desc(input logic [63:0] a, input logic [63:0] sz);
    drive(1, a, sz, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_desc_count"}, 64'(desc_count), 64'd0);
    check({tag, "_desc_full"}, 64'(desc_full), 64'd0);
    check({tag, "_busy_starved"}, 64'({busy, starved}), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd0);
    check({tag, "_err_overflow"}, 64'(err_overflow), 64'd0);
    check({tag, "_buf_addr"}, buf_addr, 64'd0);
    check({tag, "_buf_size"}, buf_size, 64'd0);
    check({tag, "_pulses"}, 64'({write_buf_update, read_buf_update, record_finish}), 64'd0);
  endtask

  // Asserts reset mid-cycle so its asynchronous effect is visible before
  // the next clock edge, then releases it on the following falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    mon_en = 1'b0;
    desc_push = 0; start = 0; stop = 0; buf_done = 0; mode = 0;
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    check({tag, "_pending_updates"}, 64'(exp_upd.size()), 64'd0);
    exp_upd.delete();
    exp_st.delete();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #3 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Record session, two descriptors, buffer rotation.
    push_desc(64'h1000, 64'h4000);
    push_desc(64'h9000, 64'h4000);
    drive(0, '0, '0, 0, 1, 0, 0);
    idle(3);
    drive(0, '0, '0, 0, 0, 0, 1);
    idle(3);
    drive(0, '0, '0, 0, 0, 0, 1);
    idle(2);
    drive(0, '0, '0, 0, 0, 1, 0);
    idle(2);

    // Replay start on an empty queue, then feed it.
    do_reset("r1");
    drive(0, '0, '0, 1, 1, 0, 0);
    idle(3);
    push_desc(64'h2000, 64'h100);
    idle(3);
    drive(0, '0, '0, 0, 0, 1, 0);
    idle(2);
    drive(0, '0, '0, 0, 0, 1, 1);
    idle(2);

    // Record stop during RUN, then drain.
    do_reset("r2");
    push_desc(64'h3000, 64'h80);
    drive(0, '0, '0, 0, 1, 0, 0);
    idle(3);
    drive(0, '0, '0, 0, 0, 1, 0);
    idle(2);
    drive(0, '0, '0, 0, 0, 1, 0);
    drive(0, '0, '0, 0, 0, 0, 1);
    idle(2);

    // Stop arriving in the ISSUE cycle.
    push_desc(64'h4000, 64'h40);
    drive(0, '0, '0, 0, 1, 0, 0);
    drive(0, '0, '0, 0, 0, 1, 0);
    idle(3);
    drive(0, '0, '0, 0, 0, 0, 1);
    idle(2);

    // Overflow, and a push against a full queue in the ISSUE cycle.
    do_reset("r3");
    for (int i = 0; i < 5; i++) push_desc(64'h10000 + 64'(i) * 64'h100, 64'h20 + 64'(i));
    idle(2);
    drive(0, '0, '0, 0, 1, 0, 0);
    drive(1, 64'hAAAA0000, 64'h55, 0, 0, 0, 0);
    idle(2);
    drive(0, '0, '0, 0, 0, 1, 1);
    idle(2);

    // Simultaneous buf_done and stop in RUN.
    do_reset("r4");
    push_desc(64'h5000, 64'h200);
    drive(0, '0, '0, 0, 1, 0, 0);
    idle(3);
    drive(0, '0, '0, 0, 0, 1, 1);
    idle(3);

    // Reset mid-RUN with three descriptors still queued.
    do_reset("r5");
    for (int i = 0; i < 4; i++) push_desc(64'h6000 + 64'(i) * 64'h10, 64'h8);
    drive(0, '0, '0, 0, 1, 0, 0);
    idle(3);
    do_reset("mid_run");

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset("rand_rst");
      end else begin
        drive($urandom_range(0, 99) < 35, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)), $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15);
      end
    end
    idle(2);
    @(negedge clk);
    mon_en = 1'b0;
    check("final_status_queue", 64'(exp_st.size()), 64'd0);
    check("final_update_queue", 64'(exp_upd.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
